// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse shaper.
package pulse_pkg;

    localparam int unsigned PS_ONESHOT = 0;
    localparam int unsigned PS_RETRIG  = 1;
    localparam int unsigned HOLDOFF_W  = 4;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_ACTIVE  = 2'd1,
        PS_HOLDOFF = 2'd2
    } ps_state_t;

endpackage

// File: rtl/load_counter.sv
// Down-counter with synchronous load, decrement enable and a count==1 flag.
module load_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/pulse_shaper.sv
// Turns single-cycle strobes into level pulses of programmable width,
// with optional retrigger and a dead window after each pulse.
module pulse_shaper
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RETRIG  = 0,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] width,
    output logic             out,
    output logic             busy,
    output logic             missed
);

    ps_state_t state;
    ps_state_t state_next;
    logic      missed_next;
    logic      pc_load;
    logic      pc_dec;
    logic      pc_last;
    logic      hc_dec;
    logic      hc_load;
    logic      hc_last;
    logic      width_ok;

    assign width_ok = (width != '0);

    // Pulse-width counter: reloaded on every accepted trigger.
    load_counter #(.W(CNT_W)) u_pulse_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (width),
        .dec      (pc_dec),
        .last     (pc_last)
    );

    // Hold-off counter: loaded as the pulse ends.
    load_counter #(.W(HOLDOFF_W)) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (hc_load),
        .load_val (HOLDOFF_W'(HOLDOFF)),
        .dec      (hc_dec),
        .last     (hc_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter controls and drop detection.
    always_comb begin
        state_next  = state;
        missed_next = 1'b0;
        pc_load     = 1'b0;
        hc_load     = 1'b0;
        case (state)
            PS_IDLE: begin
                if (trig) begin
                    if (width_ok) begin
                        pc_load    = 1'b1;
                        state_next = PS_ACTIVE;
                    end else begin
                        missed_next = 1'b1;
                    end
                end
            end
            PS_ACTIVE: begin
                if (trig && (RETRIG == PS_RETRIG) && width_ok) begin
                    pc_load = 1'b1;
                end else begin
                    missed_next = trig;
                    if (pc_last) begin
                        if (HOLDOFF > 0) begin
                            hc_load    = 1'b1;
                            state_next = PS_HOLDOFF;
                        end else begin
                            state_next = PS_IDLE;
                        end
                    end
                end
            end
            PS_HOLDOFF: begin
                // The final hold-off cycle may accept a new trigger directly.
                if (hc_last) begin
                    if (trig && width_ok) begin
                        pc_load    = 1'b1;
                        state_next = PS_ACTIVE;
                    end else begin
                        missed_next = trig;
                        state_next  = PS_IDLE;
                    end
                end else begin
                    missed_next = trig;
                end
            end
            default: begin
                state_next = PS_IDLE;
            end
        endcase
    end

    assign pc_dec = (state == PS_ACTIVE) && !pc_load;
    assign hc_dec = (state == PS_HOLDOFF);

    // Registered outputs derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out    <= 1'b0;
            busy   <= 1'b0;
            missed <= 1'b0;
        end else begin
            out    <= (state_next == PS_ACTIVE);
            busy   <= (state_next != PS_IDLE);
            missed <= missed_next;
        end
    end

endmodule

// File: tb/tb_pulse_shaper.sv
// Scoreboard bench: three configurations share one stimulus stream; a
// timing model predicts every output per edge and the predictions are
// compared one half-cycle later.
module tb_pulse_shaper;

    logic       clk;
    logic       rst;
    logic       trig;
    logic [7:0] width;
    logic       o [3];
    logic       b [3];
    logic       m [3];

    int n_vec;
    int n_err;

    typedef struct {
        logic [2:0] o;
        logic [2:0] b;
        logic [2:0] m;
    } exp_t;

    exp_t exp_q[$];

    // Model state: absolute edge numbers at which out and busy fall.
    int edge_n;
    int out_end  [3];
    int busy_end [3];
    int retrig_p [3] = '{0, 1, 0};
    int hold_p   [3] = '{2, 0, 0};

    // Measurement accumulators (sampled at negedge by the driver).
    int hi [3];
    int mc [3];
    int bc0;

    pulse_shaper #(.CNT_W(8), .RETRIG(0), .HOLDOFF(2)) u0 (
        .clk(clk), .rst(rst), .trig(trig), .width(width),
        .out(o[0]), .busy(b[0]), .missed(m[0]));

    pulse_shaper #(.CNT_W(8), .RETRIG(1), .HOLDOFF(0)) u1 (
        .clk(clk), .rst(rst), .trig(trig), .width(width),
        .out(o[1]), .busy(b[1]), .missed(m[1]));

    pulse_shaper #(.CNT_W(8), .RETRIG(0), .HOLDOFF(0)) u2 (
        .clk(clk), .rst(rst), .trig(trig), .width(width),
        .out(o[2]), .busy(b[2]), .missed(m[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int expv);
        n_vec++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Predict outputs from the timing rules on every clock edge.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                out_end[i]  = edge_n;
                busy_end[i] = edge_n;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < 3; i++) begin
                logic miss;
                miss = 1'b0;
                if (trig) begin
                    if (width == 8'd0) begin
                        miss = 1'b1;
                    end else if ((edge_n > busy_end[i]) ||
                                 (edge_n == busy_end[i] && hold_p[i] > 0)) begin
                        out_end[i]  = edge_n + int'(width);
                        busy_end[i] = edge_n + int'(width) + hold_p[i];
                    end else if (edge_n <= out_end[i] && retrig_p[i] == 1) begin
                        out_end[i]  = edge_n + int'(width);
                        busy_end[i] = edge_n + int'(width) + hold_p[i];
                    end else begin
                        miss = 1'b1;
                    end
                end
                e.o[i] = (edge_n < out_end[i]);
                e.b[i] = (edge_n < busy_end[i]);
                e.m[i] = miss;
            end
            exp_q.push_back(e);
        end
    end

    // Compare the oldest prediction against the DUTs, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d.out", i),    int'(o[i]), int'(e.o[i]));
                check($sformatf("u%0d.busy", i),   int'(b[i]), int'(e.b[i]));
                check($sformatf("u%0d.missed", i), int'(m[i]), int'(e.m[i]));
            end
        end
    end

    // One cycle: accumulate what is visible now, then set inputs for the next edge.
    task automatic cyc(input logic t, input logic [7:0] w);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            hi[i] += int'(o[i]);
            mc[i] += int'(m[i]);
        end
        bc0 += int'(b[0]);
        trig  = t;
        width = w;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'd0);
    endtask

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            hi[i] = 0;
            mc[i] = 0;
        end
        bc0 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        edge_n = 0;
        rst    = 1'b1;
        trig   = 1'b0;
        width  = 8'd0;
        clr();
        repeat (3) @(negedge clk);
        check("rst.out", int'(o[0]), 0);
        check("rst.busy", int'(b[0]), 0);
        check("rst.missed", int'(m[0]), 0);
        rst = 1'b0;
        idle(3);

        // Basic one-shot, width 5.
        clr();
        cyc(1'b1, 8'd5);
        idle(12);
        check("basic.out_cycles", hi[0], 5);
        check("basic.busy_cycles", bc0, 7);
        check("basic.missed", mc[0], 0);

        // Non-retriggerable drop: in ACTIVE and in non-final HOLDOFF.
        clr();
        cyc(1'b1, 8'd4);
        cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd4);
        cyc(1'b0, 8'd0);
        cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd4);
        idle(12);
        check("drop.out_cycles", hi[0], 4);
        check("drop.missed", mc[0], 2);

        // Retrigger after 3 cycles with a new width of 6.
        clr();
        cyc(1'b1, 8'd4);
        cyc(1'b0, 8'd0);
        cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd6);
        idle(15);
        check("retrig.out_cycles", hi[1], 9);
        check("retrig.missed", mc[1], 0);

        // Zero width is dropped.
        clr();
        cyc(1'b1, 8'd0);
        idle(5);
        check("w0.out_cycles", hi[0], 0);
        check("w0.missed", mc[0], 1);

        // Maximum width.
        clr();
        cyc(1'b1, 8'd255);
        idle(265);
        check("w255.out_cycles", hi[0], 255);
        check("w255.busy_cycles", bc0, 257);

        // Back-to-back with no hold-off.
        clr();
        cyc(1'b1, 8'd3);
        cyc(1'b0, 8'd0);
        cyc(1'b0, 8'd0);
        cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd3);
        idle(8);
        check("b2b.out_cycles", hi[2], 6);
        check("b2b.missed", mc[2], 0);

        // Trigger held high for 10 cycles.
        clr();
        repeat (10) cyc(1'b1, 8'd3);
        idle(12);
        check("held.out_cycles", hi[0], 6);
        check("held.missed", mc[0], 8);

        // Asynchronous reset in the middle of a pulse.
        cyc(1'b1, 8'd10);
        idle(3);
        check("pre_rst.out", int'(o[0]), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("arst.out%0d", i), int'(o[i]), 0);
            check($sformatf("arst.busy%0d", i), int'(b[i]), 0);
            check($sformatf("arst.missed%0d", i), int'(m[i]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr();
        idle(6);
        check("post_rst.out_cycles", hi[0], 0);
        check("post_rst.busy_cycles", bc0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
